// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn arbiter: mark encodings, FSM states,
// board size and the one-hot cell decoder.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PLAYER = 2'b01,
    PC     = 2'b10
  } mark_t;

  typedef enum logic [2:0] {
    P_TURN,
    C_TURN,
    WRITE,
    SETTLE,
    DONE
  } state_t;

  // Bit 8 is cell 1 and bit 0 is cell 9; an all-zero vector decodes to 0.
  function automatic logic [3:0] onehot_to_idx(input logic [NUM_CELLS-1:0] pos);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (pos[i]) idx = 4'(NUM_CELLS - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ttt_edge_det.sv
// One-bit rising-edge detector: rise is high while d is high and was low at the
// previous clock edge.
module ttt_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/ttt_turn_arbiter.sv
// Turn arbiter for a player-vs-PC tic-tac-toe game: validates move requests against
// board occupancy, issues one-cycle board writes and tracks turn, timeout and game end.
module ttt_turn_arbiter
  import ttt_pkg::*;
#(
  parameter bit          FIRST      = 1'b0,
  parameter int unsigned PC_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [NUM_CELLS-1:0] play_pos,
  input  logic                 pc,
  input  logic [NUM_CELLS-1:0] pc_pos,
  input  logic [NUM_CELLS-1:0] occ,
  input  logic                 win,
  output logic                 wr_en,
  output logic [3:0]           wr_idx,
  output logic [1:0]           wr_mark,
  output logic [1:0]           turn,
  output logic                 illegal,
  output logic                 timeout,
  output logic [3:0]           move_cnt,
  output logic                 game_over,
  output logic                 draw
);

  localparam state_t INIT_STATE = FIRST ? C_TURN : P_TURN;
  localparam int     TIMER_W    = (PC_TIMEOUT > 2) ? $clog2(PC_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PC_TIMEOUT - 1);

  state_t               state, state_nxt;
  mark_t                mark_q, req_mark;
  logic [3:0]           idx_q;
  logic [TIMER_W-1:0]   timer;
  logic                 play_rise, pc_rise;
  logic                 req_edge, req_legal, accept, reject;
  logic [NUM_CELLS-1:0] req_pos;

  ttt_edge_det u_play_edge (.clk(clk), .reset(reset), .d(play), .rise(play_rise));
  ttt_edge_det u_pc_edge   (.clk(clk), .reset(reset), .d(pc),   .rise(pc_rise));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_pos   = play_pos;
    req_mark  = PLAYER;
    req_edge  = 1'b0;
    if (state == P_TURN) begin
      req_edge = play_rise;
    end else if (state == C_TURN) begin
      req_pos  = pc_pos;
      req_mark = PC;
      req_edge = pc_rise;
    end
    req_legal = $onehot(req_pos) && ((req_pos & occ) == '0);
    accept    = req_edge && req_legal;
    reject    = req_edge && !req_legal;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      P_TURN, C_TURN: if (accept) state_nxt = WRITE;
      WRITE:          state_nxt = SETTLE;
      SETTLE: begin
        if (win || move_cnt == 4'(NUM_CELLS)) state_nxt = DONE;
        else if (mark_q == PLAYER)            state_nxt = C_TURN;
        else                                  state_nxt = P_TURN;
      end
      default:        state_nxt = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT_STATE;
      mark_q   <= EMPTY;
      idx_q    <= '0;
      move_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      timer    <= '0;
    end else begin
      state   <= state_nxt;
      illegal <= reject;
      timeout <= 1'b0;
      if (accept) begin
        mark_q   <= req_mark;
        idx_q    <= onehot_to_idx(req_pos);
        move_cnt <= move_cnt + 4'd1;
      end
      // Timer runs only while the PC keeps the turn; leaving C_TURN rearms it.
      if (state == C_TURN && state_nxt == C_TURN) begin
        if (timer == TIMER_LAST) begin
          timer   <= '0;
          timeout <= 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        timer <= '0;
      end
    end
  end

  // Gating with reset keeps a write that is in flight from reaching the board.
  assign wr_en   = (state == WRITE) && !reset;
  assign wr_idx  = wr_en ? idx_q : 4'd0;
  assign wr_mark = wr_en ? mark_q : EMPTY;

  always_comb begin
    case (state)
      P_TURN:        turn = PLAYER;
      C_TURN:        turn = PC;
      WRITE, SETTLE: turn = mark_q;
      default:       turn = EMPTY;
    endcase
  end

  assign game_over = (state == DONE);
  assign draw      = game_over && (move_cnt == 4'(NUM_CELLS)) && !win;

endmodule
